// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding and widths for the Game-of-Life grid driver.
package gol_pkg;
    typedef enum logic [2:0] {IDLE, LD_WAIT, LD_WR, SCAN, EMIT, STEP} state_t;
    localparam int GEN_CNT_W = 16;
endpackage

// File: rtl/gol_row_shifter.sv
// gol_row_shifter: one row-word buffer with parallel load, single-bit capture and parallel read.
module gol_row_shifter #(
    parameter int K = 6
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 ld,
    input  logic [(1<<K)-1:0]    ld_data,
    input  logic                 wr,
    input  logic [K-1:0]         idx,
    input  logic                 bit_in,
    output logic [(1<<K)-1:0]    data
);
    // Whole-word load wins over a single-bit capture.
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) data <= '0;
        else if (ld) data <= ld_data;
        else if (wr) data[idx] <= bit_in;
endmodule

// File: rtl/gol_grid_driver.sv
// gol_grid_driver: loads a seed into the cell grid, scans it out row by row, and steps generations.
module gol_grid_driver
    import gol_pkg::*;
#(
    parameter int K       = 6,
    parameter int GEN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  load,
    input  logic                  en,
    input  logic                  run,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [(1<<K)-1:0]     seed_data,
    output logic                  write_en,
    output logic [K-1:0]          wAddrR,
    output logic [K-1:0]          wAddrC,
    output logic                  write_data,
    output logic                  change_state,
    output logic [K-1:0]          rAddrR,
    output logic [K-1:0]          rAddrC,
    input  logic                  read_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [(1<<K)-1:0]     row_data,
    output logic [K-1:0]          row_idx,
    output logic                  frame_last,
    output logic [GEN_CNT_W-1:0]  gen_count,
    output logic                  busy
);
    localparam int KPOW = 1 << K;
    localparam logic [K-1:0] LAST = {K{1'b1}};
    localparam logic [7:0] GD = 8'(GEN_DIV);

    state_t state, nxt;
    logic [K-1:0] row, col, load_row;
    logic [7:0] frame_cnt;
    logic load_pend;
    logic [KPOW-1:0] seed_q, scan_q;
    logic last_col, want_load, do_step;

    assign last_col  = col == LAST;
    assign want_load = load | load_pend;
    assign do_step   = run && (frame_cnt + 8'd1 == GD);

    gol_row_shifter #(.K(K)) u_seed (
        .clk(clk), .rst_b(rst_b), .ld(state == LD_WAIT && seed_valid), .ld_data(seed_data),
        .wr(1'b0), .idx(col), .bit_in(1'b0), .data(seed_q)
    );

    gol_row_shifter #(.K(K)) u_scan (
        .clk(clk), .rst_b(rst_b), .ld(1'b0), .ld_data('0),
        .wr(state == SCAN), .idx(col), .bit_in(read_data), .data(scan_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else state <= nxt;

    // Next state and state-decoded grid/stream outputs; addresses are zero outside their states.
    always_comb begin
        nxt = state;
        seed_ready   = state == LD_WAIT;
        write_en     = state == LD_WR;
        wAddrR       = write_en ? load_row : '0;
        wAddrC       = write_en ? col : '0;
        write_data   = write_en & seed_q[col];
        rAddrR       = state == SCAN ? row : '0;
        rAddrC       = state == SCAN ? col : '0;
        row_valid    = state == EMIT;
        row_data     = row_valid ? scan_q : '0;
        row_idx      = row_valid ? row : '0;
        frame_last   = row_valid && row == LAST;
        change_state = state == STEP;
        busy         = state != IDLE;
        case (state)
            IDLE:    nxt = want_load ? LD_WAIT : en ? SCAN : IDLE;
            LD_WAIT: nxt = seed_valid ? LD_WR : LD_WAIT;
            LD_WR:   nxt = !last_col ? LD_WR : load_row == LAST ? IDLE : LD_WAIT;
            SCAN:    nxt = last_col ? EMIT : SCAN;
            EMIT:    nxt = !row_ready ? EMIT : row != LAST ? SCAN : do_step ? STEP :
                           (want_load || !en) ? IDLE : SCAN;
            STEP:    nxt = (want_load || !en) ? IDLE : SCAN;
            default: nxt = IDLE;
        endcase
    end

    // Cell/row/frame/generation counters; a load seen outside IDLE waits for the frame boundary.
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            col       <= '0;
            row       <= '0;
            load_row  <= '0;
            frame_cnt <= '0;
            gen_count <= '0;
            load_pend <= 1'b0;
        end else begin
            col <= (state == LD_WR || state == SCAN) ? col + K'(1) : '0;
            if (state == LD_WR && last_col) load_row <= load_row + K'(1);
            if (state == EMIT && row_ready) row <= row + K'(1);
            if (state == EMIT && row_ready && row == LAST && run) frame_cnt <= do_step ? 8'd0 : frame_cnt + 8'd1;
            if (state == STEP) gen_count <= gen_count + GEN_CNT_W'(1);
            load_pend <= state == IDLE ? 1'b0 :
                         load_pend | (load && (state == SCAN || state == EMIT || state == STEP));
        end
endmodule

// File: tb/tb_gol_grid_driver.sv
// tb_gol_grid_driver: drives the grid driver against a behavioural Life grid and scoreboard.
module tb_gol_grid_driver;
    localparam int K = 2, KPOW = 4, N = 16, GEN_DIV = 1;

    logic clk = 0, rst_b = 0, load = 0, en = 0, run = 0, seed_valid = 0, row_ready = 0;
    logic [KPOW-1:0] seed_data = '0;
    logic seed_ready, write_en, write_data, change_state, read_data, row_valid, frame_last, busy;
    logic [K-1:0] wAddrR, wAddrC, rAddrR, rAddrC, row_idx;
    logic [KPOW-1:0] row_data;
    logic [15:0] gen_count;
    logic [N-1:0] grid = '0;
    int errors = 0, checks = 0;
    logic rand_ready = 0;

    gol_grid_driver #(.K(K), .GEN_DIV(GEN_DIV)) dut (
        .clk(clk), .rst_b(rst_b), .load(load), .en(en), .run(run),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
        .write_en(write_en), .wAddrR(wAddrR), .wAddrC(wAddrC), .write_data(write_data),
        .change_state(change_state), .rAddrR(rAddrR), .rAddrC(rAddrC), .read_data(read_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx),
        .frame_last(frame_last), .gen_count(gen_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] life(input logic [N-1:0] g);
        logic [N-1:0] n;
        n = '0;
        for (int r = 0; r < KPOW; r++)
            for (int c = 0; c < KPOW; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < KPOW && c + dc >= 0 && c + dc < KPOW)
                            cnt += int'(g[(r + dr) * KPOW + c + dc]);
                n[r * KPOW + c] = (cnt == 3) || (cnt == 2 && g[r * KPOW + c]);
            end
        return n;
    endfunction

    // Behavioural cell grid: combinational read, written by write_en, advanced by change_state.
    assign read_data = grid[{rAddrR, rAddrC}];
    always @(posedge clk)
        if (write_en) grid[{wAddrR, wAddrC}] <= write_data;
        else if (change_state) grid <= life(grid);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int exp_row = 0, mf = 0, wr_left = 0, wcol = 0, wrow = 0, gap = 0, frame_done = 0, writes = 0;
    logic [15:0] mgen = 0;
    logic step_due = 0, stall_prev = 0, prev_valid = 0, gap_arm = 0;
    logic [KPOW-1:0] sd = '0, pdata = '0;
    logic [K-1:0] pidx = '0;
    logic [KPOW-1:0] last_frame [KPOW];

    // Scoreboard: every cycle, compare DUT outputs with what the rules say they must be.
    always @(negedge clk) begin
        if (!rst_b) begin
            chk("reset_outs", {seed_ready, write_en, wAddrR, wAddrC, write_data, change_state, rAddrR, rAddrC,
                               row_valid, row_data, row_idx, frame_last, gen_count, busy}, 0);
            exp_row = 0; mf = 0; wr_left = 0; wrow = 0; mgen = 0;
            step_due = 0; stall_prev = 0; prev_valid = 0; gap_arm = 0;
        end else begin
            chk("exclusive", write_en & change_state, 0);
            chk("change_state", change_state, step_due);
            step_due = 0;
            chk("gen_count", gen_count, mgen);
            if (change_state) mgen = mgen + 16'd1;
            chk("write_en", write_en, wr_left > 0);
            if (wr_left > 0) begin
                chk("wAddrR", wAddrR, wrow);
                chk("wAddrC", wAddrC, wcol);
                chk("write_data", write_data, sd[wcol]);
                wcol++; wr_left--; writes++;
                if (wr_left == 0) wrow = (wrow + 1) % KPOW;
            end
            if (seed_valid && seed_ready) begin
                sd = seed_data; wr_left = KPOW; wcol = 0;
            end
            if (stall_prev) begin
                chk("stall_valid", row_valid, 1);
                chk("stall_data", row_data, pdata);
                chk("stall_idx", row_idx, pidx);
            end
            gap++;
            if (row_valid && !prev_valid && gap_arm) begin
                chk("scan_gap", gap, KPOW + 1);
                gap_arm = 0;
            end
            if (row_valid) begin
                chk("row_idx", row_idx, exp_row);
                chk("row_data", row_data, grid[exp_row * KPOW +: KPOW]);
                chk("frame_last", frame_last, exp_row == KPOW - 1);
                if (row_ready) begin
                    last_frame[exp_row] = row_data;
                    if (exp_row == KPOW - 1) begin
                        frame_done++;
                        if (run) begin
                            mf++;
                            if (mf == GEN_DIV) begin mf = 0; step_due = 1; end
                        end
                    end else begin
                        gap = 0; gap_arm = 1;
                    end
                    exp_row = (exp_row + 1) % KPOW;
                end
            end else chk("frame_last_low", frame_last, 0);
            stall_prev = row_valid && !row_ready;
            pdata = row_data; pidx = row_idx; prev_valid = row_valid;
        end
    end

    // Random downstream back-pressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) row_ready = $urandom_range(0, 3) != 0;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_seed(input logic [KPOW-1:0] d);
        logic ok;
        int k;
        seed_valid = 1; seed_data = d; k = 0; ok = 0;
        do begin
            @(negedge clk); ok = seed_ready;
            @(posedge clk); #1; k++;
        end while (!ok && k < 300);
        chk("seed_accept", ok, 1);
        seed_valid = 0;
        cyc($urandom_range(0, 3));
    endtask

    task automatic wait_frames(input int n);
        int target, k;
        target = frame_done + n; k = 0;
        while (frame_done < target && k < 3000) begin cyc(1); k++; end
        chk("frame_wait", frame_done >= target, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 500) begin cyc(1); k++; end
        chk("idle", busy, 0);
    endtask

    task automatic wait_row(input int idx, input logic need_ready);
        int k;
        logic hit;
        k = 0; hit = 0;
        while (!hit && k < 500) begin
            @(negedge clk);
            hit = row_valid && row_idx == K'(idx) && (!need_ready || row_ready);
            k++;
        end
        chk("row_wait", hit, 1);
    endtask

    task automatic chk_frame(input string name, input logic [4*KPOW-1:0] exp);
        for (int r = 0; r < KPOW; r++) chk(name, last_frame[r], exp[r * KPOW +: KPOW]);
    endtask

    initial begin
        logic [KPOW-1:0] rs [KPOW];
        int fd, k;
        logic hit;
        cyc(3);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gen", gen_count, 0);
        @(posedge clk); #1 rst_b = 1;
        cyc(2);

        // Seed a horizontal blinker on row 1 with scanning disabled.
        load = 1; cyc(1); load = 0;
        send_seed(4'b0000); send_seed(4'b0111); send_seed(4'b0000); send_seed(4'b0000);
        wait_idle();
        chk("grid_loaded", grid, 16'h0070);
        chk("write_count", writes, 16);

        // Scan with run=0: the frame repeats, no generation step.
        en = 1; run = 0; row_ready = 1;
        wait_frames(2);
        chk_frame("frame_seed", {4'b0000, 4'b0000, 4'b0111, 4'b0000});
        chk("gen_hold", gen_count, 0);

        // Back-pressure on row 1 for 10 cycles.
        wait_row(0, 1);
        @(posedge clk); #1 row_ready = 0;
        wait_row(1, 0);
        chk("stall_row1_data", row_data, 4'b0111);
        cyc(10);
        @(negedge clk);
        chk("stall_held", row_valid, 1);
        chk("stall_no_scan", {rAddrR, rAddrC}, 0);
        @(posedge clk); #1 row_ready = 1;

        // Generation stepping: blinker flips to vertical, then back.
        wait_frames(1);
        run = 1;
        wait_frames(1);
        rand_ready = 1;
        wait_frames(1);
        chk_frame("frame_gen1", {4'b0000, 4'b0010, 4'b0010, 4'b0010});
        chk("gen_one", gen_count, 1);
        wait_frames(1);
        chk_frame("frame_gen2", {4'b0000, 4'b0000, 4'b0111, 4'b0000});
        run = 0;
        wait_frames(1);

        // Dropping en mid-frame lets exactly the current frame finish.
        wait_row(1, 0);
        @(posedge clk); #1 en = 0;
        fd = frame_done;
        wait_idle();
        chk("en_drop_frame", frame_done, fd + 1);

        // Mid-frame load waits for the frame boundary, then random seed rows load.
        en = 1;
        wait_row(1, 0);
        @(posedge clk); #1 load = 1;
        fd = frame_done;
        cyc(1); load = 0;
        k = 0; hit = 0;
        while (!hit && k < 500) begin @(negedge clk); hit = seed_ready; k++; end
        chk("load_after_frame", frame_done, fd + 1);
        @(posedge clk); #1;
        for (int r = 0; r < KPOW; r++) begin
            rs[r] = KPOW'($urandom);
            send_seed(rs[r]);
        end
        wait_frames(2);
        for (int r = 0; r < KPOW; r++) chk("frame_random", last_frame[r], rs[r]);

        // Asynchronous reset in the middle of a row write.
        en = 0;
        wait_idle();
        load = 1; cyc(1); load = 0;
        seed_valid = 1; seed_data = KPOW'($urandom);
        k = 0; hit = 0;
        while (!hit && k < 200) begin @(negedge clk); hit = write_en && wAddrC == 2'd2; k++; end
        chk("reach_col2", hit, 1);
        #2 rst_b = 0; seed_valid = 0;
        #1 chk("async_reset", {seed_ready, write_en, wAddrR, wAddrC, write_data, change_state, rAddrR, rAddrC,
                                row_valid, row_data, row_idx, frame_last, gen_count, busy}, 0);
        cyc(2);
        rst_b = 1;
        cyc(2);
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_gen", gen_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
